// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry skid
// buffer (registered ready), synchronous flush and bubble insertion on empty slots.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter bit               SKID       = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_flush,
    output logic [1:0]       o_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_p0, state_n;
    logic [WIDTH-1:0] main_p0, main_n;
    logic [WIDTH-1:0] skid_p0, skid_n;
    logic             en_p0;
    logic             accept;
    logic             emit;

    assign o_valid = (state_p0 != ST_EMPTY);
    assign o_data  = main_p0;
    assign o_count = state_p0;
    assign accept  = i_valid && o_ready;
    assign emit    = o_valid && i_ready;

    // Skid mode derives ready purely from flops, so i_ready never reaches o_ready.
    generate
        if (SKID) begin : g_ready_reg
            assign o_ready = en_p0 && (state_p0 != ST_FULL);
        end else begin : g_ready_comb
            assign o_ready = en_p0 && (!o_valid || i_ready);
        end
    endgenerate

    always_comb begin
        state_n = state_p0;
        main_n  = main_p0;
        skid_n  = skid_p0;
        case (state_p0)
            ST_EMPTY: begin
                if (accept) begin
                    main_n  = i_data;
                    state_n = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    main_n = i_data;
                end else if (accept) begin
                    skid_n  = i_data;
                    state_n = ST_FULL;
                end else if (emit) begin
                    main_n  = BUBBLE_VAL;
                    state_n = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    main_n  = skid_p0;
                    skid_n  = BUBBLE_VAL;
                    state_n = ST_ONE;
                end
            end
            default: begin
                main_n  = BUBBLE_VAL;
                skid_n  = BUBBLE_VAL;
                state_n = ST_EMPTY;
            end
        endcase
        // Flush wins over everything; an emit this cycle has already completed downstream.
        if (i_flush) begin
            main_n  = BUBBLE_VAL;
            skid_n  = BUBBLE_VAL;
            state_n = ST_EMPTY;
        end
    end

    // ---- stage p0 registers ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0 <= ST_EMPTY;
            en_p0    <= 1'b0;
        end else begin
            state_p0 <= state_n;
            en_p0    <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_p0 <= BUBBLE_VAL;
            skid_p0 <= BUBBLE_VAL;
        end else begin
            main_p0 <= main_n;
            skid_p0 <= skid_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid: instance 0 with the skid buffer,
// instance 1 in single-register mode, both with a NOP bubble value.
module tb_pipe_stage_skid;

    localparam logic [31:0] BUB = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid [2];
    logic        s_ready [2];
    logic        s_flush [2];
    logic [31:0] s_data  [2];
    logic        s_ov    [2];
    logic        s_or    [2];
    logic [31:0] s_od    [2];
    logic [1:0]  s_cnt   [2];

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] sb   [2][4];
    int          head [2];
    int          tail [2];
    logic        hold [2];
    logic        acc;
    logic        emt;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(s_valid[0]), .o_ready(s_or[0]), .i_data(s_data[0]),
        .o_valid(s_ov[0]), .i_ready(s_ready[0]), .o_data(s_od[0]),
        .i_flush(s_flush[0]), .o_count(s_cnt[0])
    );

    pipe_stage_skid #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(s_valid[1]), .o_ready(s_or[1]), .i_data(s_data[1]),
        .o_valid(s_ov[1]), .i_ready(s_ready[1]), .o_data(s_od[1]),
        .i_flush(s_flush[1]), .o_count(s_cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input int d, input logic v, input logic [31:0] dt,
                       input logic r, input logic f);
        s_valid[d] = v;
        s_data[d]  = dt;
        s_ready[d] = r;
        s_flush[d] = f;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b1;
            s_data[d]  = 32'hDEADBEEF;
            s_ready[d] = 1'b0;
            s_flush[d] = 1'b0;
            head[d]    = 0;
            tail[d]    = 0;
            hold[d]    = 1'b0;
        end

        // Reset held for three cycles with a valid beat offered
        repeat (3) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                chk("rst_valid", 32'(s_ov[d]), 32'd0);
                chk("rst_data", s_od[d], BUB);
                chk("rst_ready", 32'(s_or[d]), 32'd0);
            end
        end
        rst_n = 1'b1;
        drv(0, 1'b0, 32'd0, 1'b0, 1'b0);
        drv(1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("rel_ready_before_edge", 32'(s_or[0]), 32'd0);
        cyc();
        chk("rel_ready_a", 32'(s_or[0]), 32'd1);
        chk("rel_ready_b", 32'(s_or[1]), 32'd1);
        chk("rel_count", 32'(s_cnt[0]), 32'd0);

        // Streaming through the skid instance
        for (int k = 1; k <= 4; k++) begin
            drv(0, 1'b1, 32'(k), 1'b1, 1'b0);
            if (k > 1) chk("stream_prev", s_od[0], 32'(k - 1));
            cyc();
            chk("stream_data", s_od[0], 32'(k));
            chk("stream_valid", 32'(s_ov[0]), 32'd1);
            chk("stream_count", 32'(s_cnt[0]), 32'd1);
        end
        drv(0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc();
        chk("stream_drain_valid", 32'(s_ov[0]), 32'd0);
        chk("stream_drain_data", s_od[0], BUB);

        // Stall absorbs the in-flight beat in the skid register
        drv(0, 1'b1, 32'd10, 1'b0, 1'b0);
        cyc();
        chk("stall_first", s_od[0], 32'd10);
        drv(0, 1'b1, 32'd11, 1'b0, 1'b0);
        chk("stall_ready_one", 32'(s_or[0]), 32'd1);
        cyc();
        chk("stall_count", 32'(s_cnt[0]), 32'd2);
        chk("stall_ready_full", 32'(s_or[0]), 32'd0);
        chk("stall_hold", s_od[0], 32'd10);
        drv(0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("skid_emit10", s_od[0], 32'd10);
        cyc();
        chk("skid_emit11", s_od[0], 32'd11);
        chk("skid_count1", 32'(s_cnt[0]), 32'd1);
        cyc();
        chk("skid_empty_data", s_od[0], BUB);
        chk("skid_empty_valid", 32'(s_ov[0]), 32'd0);

        // Flush colliding with an emit while full
        drv(0, 1'b1, 32'd20, 1'b0, 1'b0);
        cyc();
        drv(0, 1'b1, 32'd21, 1'b0, 1'b0);
        cyc();
        chk("flush_full", 32'(s_cnt[0]), 32'd2);
        drv(0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("flush_emit20", s_od[0], 32'd20);
        chk("flush_emit_valid", 32'(s_ov[0]), 32'd1);
        cyc();
        chk("flush_valid", 32'(s_ov[0]), 32'd0);
        chk("flush_count", 32'(s_cnt[0]), 32'd0);
        chk("flush_data", s_od[0], BUB);
        chk("flush_ready", 32'(s_or[0]), 32'd1);
        drv(0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc();
        chk("flush_no21", 32'(s_ov[0]), 32'd0);
        drv(0, 1'b1, 32'd30, 1'b1, 1'b1);
        cyc();
        chk("flush_drop_accept", 32'(s_ov[0]), 32'd0);
        chk("flush_drop_count", 32'(s_cnt[0]), 32'd0);
        drv(0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Single-register mode: ready follows i_ready combinationally
        drv(1, 1'b1, 32'd5, 1'b0, 1'b0);
        chk("b_ready_empty", 32'(s_or[1]), 32'd1);
        cyc();
        chk("b_data5", s_od[1], 32'd5);
        drv(1, 1'b1, 32'd6, 1'b0, 1'b0);
        chk("b_ready_stall", 32'(s_or[1]), 32'd0);
        cyc();
        chk("b_hold5", s_od[1], 32'd5);
        chk("b_count_hold", 32'(s_cnt[1]), 32'd1);
        drv(1, 1'b1, 32'd6, 1'b1, 1'b0);
        chk("b_ready_comb", 32'(s_or[1]), 32'd1);
        cyc();
        chk("b_data6", s_od[1], 32'd6);
        chk("b_count1", 32'(s_cnt[1]), 32'd1);
        drv(1, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc();
        chk("b_empty", 32'(s_ov[1]), 32'd0);
        chk("b_empty_data", s_od[1], BUB);

        // Random soak with a scoreboard per instance
        for (int n = 0; n < 10000; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!s_ov[d]) chk(d == 0 ? "a_bubble" : "b_bubble", s_od[d], BUB);
                chk(d == 0 ? "a_count" : "b_count", 32'(s_cnt[d]), 32'(tail[d] - head[d]));
                if (!hold[d]) begin
                    s_valid[d] = 1'($urandom_range(0, 1));
                    s_data[d]  = $urandom;
                end
                s_ready[d] = ($urandom_range(0, 3) != 0);
                s_flush[d] = ($urandom_range(0, 63) == 0);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                acc = s_valid[d] && s_or[d];
                emt = s_ov[d] && s_ready[d];
                if (emt) begin
                    chk(d == 0 ? "a_emit_expected" : "b_emit_expected",
                        32'(tail[d] != head[d]), 32'd1);
                    if (tail[d] != head[d]) begin
                        chk(d == 0 ? "a_stream" : "b_stream", s_od[d], sb[d][head[d] % 4]);
                        head[d]++;
                    end
                end
                if (s_flush[d]) begin
                    head[d] = tail[d];
                end else if (acc) begin
                    sb[d][tail[d] % 4] = s_data[d];
                    tail[d]++;
                end
                hold[d] = s_valid[d] && !acc;
            end
            cyc();
        end

        // Asynchronous reset mid-operation clears without a clock edge
        drv(0, 1'b1, 32'd40, 1'b0, 1'b0);
        drv(1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc();
        chk("async_pre_valid", 32'(s_ov[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(s_ov[0]), 32'd0);
        chk("async_count", 32'(s_cnt[0]), 32'd0);
        chk("async_data", s_od[0], BUB);
        chk("async_ready", 32'(s_or[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
